// File: rtl/axi_lite_mem_param_if.sv
// AXI4-Lite slave bus bundle for axi_lite_mem_param: AW, W, B, AR and R channels.
interface axi_lite_mem_param_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]     s_awaddr;
    logic                  s_awvalid;
    logic                  s_awready;
    logic [DATA_W-1:0]     s_wdata;
    logic [DATA_W/8-1:0]   s_wstrb;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [1:0]            s_bresp;
    logic                  s_bvalid;
    logic                  s_bready;
    logic [ADDR_W-1:0]     s_araddr;
    logic                  s_arvalid;
    logic                  s_arready;
    logic [DATA_W-1:0]     s_rdata;
    logic [1:0]            s_rresp;
    logic                  s_rvalid;
    logic                  s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axi_lite_mem_param.sv
// Parametrised AXI4-Lite slave RAM with byte strobes, SLVERR on out-of-range access and
// independent read/write channels. Optional low-word write protection: AXI_MEM_WPROT_EN.
module axi_lite_mem_param #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WPROT_WORDS = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    axi_lite_mem_param_if.slave   s
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
`ifdef AXI_MEM_WPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    wstate_t             wstate_q;
    logic                awready_q, wready_q, bvalid_q;
    logic [1:0]          bresp_q;
    logic                aw_held_q, w_held_q;
    logic [ADDR_W-1:0]   awaddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;

    rstate_t             rstate_q;
    logic                arready_q, rvalid_q;
    logic [1:0]          rresp_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                aw_hs_c, w_hs_c, commit_c, wr_ok_c, ar_hs_c, rd_ok_c;
    logic [ADDR_W-1:0]   wr_addr_c, wr_word_c, rd_word_c;
    logic [DATA_W-1:0]   wr_data_c;
    logic [STRB_W-1:0]   wr_strb_c;
    logic [IDX_W-1:0]    wr_idx_c, rd_idx_c;

    // A write commits on the edge where both halves are available, held or arriving now.
    always_comb begin
        aw_hs_c   = s.s_awvalid && awready_q;
        w_hs_c    = s.s_wvalid && wready_q;
        wr_addr_c = aw_held_q ? awaddr_q : s.s_awaddr;
        wr_data_c = w_held_q  ? wdata_q  : s.s_wdata;
        wr_strb_c = w_held_q  ? wstrb_q  : s.s_wstrb;
        commit_c  = (wstate_q == W_IDLE) && (aw_held_q || aw_hs_c) && (w_held_q || w_hs_c);
        wr_word_c = ADDR_W'(wr_addr_c >> OFF_W);
        wr_idx_c  = wr_word_c[IDX_W-1:0];
        wr_ok_c   = (wr_word_c < ADDR_W'(DEPTH)) &&
                    !(PROT_EN && (wr_word_c < ADDR_W'(WPROT_WORDS)));
        ar_hs_c   = s.s_arvalid && arready_q;
        rd_word_c = ADDR_W'(s.s_araddr >> OFF_W);
        rd_idx_c  = rd_word_c[IDX_W-1:0];
        rd_ok_c   = rd_word_c < ADDR_W'(DEPTH);
    end

    // Storage is never reset; only strobed bytes of legal writes are updated.
    always_ff @(posedge aclk) begin
        if (!areset && commit_c && wr_ok_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb_c[b]) mem_q[wr_idx_c][b*8 +: 8] <= wr_data_c[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (aw_hs_c) begin
                        awaddr_q  <= s.s_awaddr;
                        aw_held_q <= 1'b1;
                        awready_q <= 1'b0;
                    end
                    if (w_hs_c) begin
                        wdata_q  <= s.s_wdata;
                        wstrb_q  <= s.s_wstrb;
                        w_held_q <= 1'b1;
                        wready_q <= 1'b0;
                    end
                    if (commit_c) begin
                        wstate_q  <= W_RESP;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_ok_c ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                W_RESP: begin
                    if (s.s_bready) begin
                        wstate_q  <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read sees the pre-write word when a write commits to it on the same edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (ar_hs_c) begin
                        rstate_q  <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= rd_ok_c ? RESP_OKAY : RESP_SLVERR;
                        rdata_q   <= rd_ok_c ? mem_q[rd_idx_c] : '0;
                    end
                end
                R_DATA: begin
                    if (s.s_rready) begin
                        rstate_q  <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s.s_awready = awready_q;
    assign s.s_wready  = wready_q;
    assign s.s_bvalid  = bvalid_q;
    assign s.s_bresp   = bresp_q;
    assign s.s_arready = arready_q;
    assign s.s_rvalid  = rvalid_q;
    assign s.s_rresp   = rresp_q;
    assign s.s_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_lite_mem_param.sv
// Directed bench for axi_lite_mem_param (DATA_W=32, DEPTH=1024); protection checks when AXI_MEM_WPROT_EN is set.
module tb_axi_lite_mem_param;
    logic aclk = 1'b0;
    logic areset;
    int   total = 0;
    int   bad   = 0;

    axi_lite_mem_param_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_mem_param #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .WPROT_WORDS(16)) dut (
        .aclk  (aclk),
        .areset(areset),
        .s     (bus.slave)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_bus();
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit ok);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        bus.s_awaddr = addr; bus.s_wdata = data; bus.s_wstrb = strb;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = bus.s_awvalid && bus.s_awready;
            w_now  = bus.s_wvalid && bus.s_wready;
            tick(); n++;
            if (aw_now) begin aw_done = 1; bus.s_awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  bus.s_wvalid = 1'b0;  end
        end
        while (!bus.s_bvalid && n < 20) begin tick(); n++; end
        resp = bus.s_bresp;
        ok = (n < 20) && bus.s_bvalid;
        tick();
        bus.s_bready = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output bit rv_next, output bit ok);
        bit done = 0, ar_now;
        int n = 0;
        bus.s_araddr = addr; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
        while (!done && n < 20) begin
            ar_now = bus.s_arready;
            tick(); n++;
            if (ar_now) begin done = 1; bus.s_arvalid = 1'b0; end
        end
        rv_next = bus.s_rvalid;
        data = bus.s_rdata;
        resp = bus.s_rresp;
        ok = done && bus.s_rvalid;
        bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
    endtask

    task automatic test_reset();
        total++; if (bus.s_awready !== 1'b1) begin bad++; $display("FAIL rst_awready got=%b exp=1", bus.s_awready); end
        total++; if (bus.s_wready  !== 1'b1) begin bad++; $display("FAIL rst_wready got=%b exp=1", bus.s_wready); end
        total++; if (bus.s_arready !== 1'b1) begin bad++; $display("FAIL rst_arready got=%b exp=1", bus.s_arready); end
        total++; if (bus.s_bvalid  !== 1'b0) begin bad++; $display("FAIL rst_bvalid got=%b exp=0", bus.s_bvalid); end
        total++; if (bus.s_rvalid  !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.s_rvalid); end
        total++; if (bus.s_bresp   !== 2'b00) begin bad++; $display("FAIL rst_bresp got=%b exp=00", bus.s_bresp); end
        total++; if (bus.s_rresp   !== 2'b00) begin bad++; $display("FAIL rst_rresp got=%b exp=00", bus.s_rresp); end
        total++; if (bus.s_rdata   !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.s_rdata); end
    endtask

    task automatic test_basic();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        do_write(32'h4, 32'hDEADBEEF, 4'hF, resp, ok);
        total++; if (!ok || resp !== 2'b00) begin bad++; $display("FAIL basic_bresp got=%b ok=%0d exp=00", resp, ok); end
        do_read(32'h4, d, resp, rv, ok);
        total++; if (rv !== 1'b1) begin bad++; $display("FAIL basic_rvalid_latency got=%b exp=1", rv); end
        total++; if (!ok || d !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rdata got=%h exp=deadbeef", d); end
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL basic_rresp got=%b exp=00", resp); end
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        do_write(32'h8, 32'h11223344, 4'hF, resp, ok);
        do_write(32'h8, 32'hAABBCCDD, 4'h5, resp, ok);
        total++; if (!ok || resp !== 2'b00) begin bad++; $display("FAIL strb_bresp got=%b exp=00", resp); end
        do_read(32'h8, d, resp, rv, ok);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL strb_merge got=%h exp=11bb33dd", d); end
        do_write(32'h8, 32'hFFFFFFFF, 4'h0, resp, ok);
        total++; if (!ok || resp !== 2'b00) begin bad++; $display("FAIL strb0_bresp got=%b exp=00", resp); end
        do_read(32'h8, d, resp, rv, ok);
        total++; if (d !== 32'h11BB33DD) begin bad++; $display("FAIL strb0_noop got=%h exp=11bb33dd", d); end
    endtask

    task automatic test_decoupled();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        // AW first, W three cycles later
        bus.s_awaddr = 32'h20; bus.s_awvalid = 1'b1;
        tick(); bus.s_awvalid = 1'b0;
        total++; if (bus.s_awready !== 1'b0) begin bad++; $display("FAIL dec_awready_c1 got=%b exp=0", bus.s_awready); end
        tick();
        total++; if (bus.s_awready !== 1'b0 || bus.s_bvalid !== 1'b0) begin bad++; $display("FAIL dec_c2 awready=%b bvalid=%b exp=0,0", bus.s_awready, bus.s_bvalid); end
        tick();
        total++; if (bus.s_awready !== 1'b0) begin bad++; $display("FAIL dec_awready_c3 got=%b exp=0", bus.s_awready); end
        bus.s_wdata = 32'hA5A55A5A; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick(); bus.s_wvalid = 1'b0;
        total++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin bad++; $display("FAIL dec_b got bvalid=%b bresp=%b exp=1,00", bus.s_bvalid, bus.s_bresp); end
        bus.s_bready = 1'b1; tick(); bus.s_bready = 1'b0;
        total++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1) begin bad++; $display("FAIL dec_release bvalid=%b awready=%b wready=%b exp=0,1,1", bus.s_bvalid, bus.s_awready, bus.s_wready); end
        do_read(32'h20, d, resp, rv, ok);
        total++; if (d !== 32'hA5A55A5A) begin bad++; $display("FAIL dec_aw_first_rd got=%h exp=a5a55a5a", d); end
        // W first, AW two cycles later
        bus.s_wdata = 32'h0BADCAFE; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
        tick(); bus.s_wvalid = 1'b0;
        total++; if (bus.s_wready !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_bvalid !== 1'b0) begin bad++; $display("FAIL dec_wfirst wready=%b awready=%b bvalid=%b exp=0,1,0", bus.s_wready, bus.s_awready, bus.s_bvalid); end
        tick();
        bus.s_awaddr = 32'h24; bus.s_awvalid = 1'b1;
        tick(); bus.s_awvalid = 1'b0;
        total++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin bad++; $display("FAIL dec_wfirst_b bvalid=%b bresp=%b exp=1,00", bus.s_bvalid, bus.s_bresp); end
        bus.s_bready = 1'b1; tick(); bus.s_bready = 1'b0;
        do_read(32'h24, d, resp, rv, ok);
        total++; if (d !== 32'h0BADCAFE) begin bad++; $display("FAIL dec_w_first_rd got=%h exp=0badcafe", d); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        bus.s_awaddr = 32'h4; bus.s_wdata = 32'h0F0F0F0F; bus.s_wstrb = 4'hF; bus.s_araddr = 32'h4;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        total++; if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rw_same_edge rvalid=%b rdata=%h exp=1,deadbeef", bus.s_rvalid, bus.s_rdata); end
        total++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin bad++; $display("FAIL rw_same_edge_b bvalid=%b bresp=%b exp=1,00", bus.s_bvalid, bus.s_bresp); end
        bus.s_bready = 1'b1; bus.s_rready = 1'b1; tick(); bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        do_read(32'h4, d, resp, rv, ok);
        total++; if (d !== 32'h0F0F0F0F) begin bad++; $display("FAIL rw_after got=%h exp=0f0f0f0f", d); end
    endtask

    task automatic test_backpressure();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        bus.s_awaddr = 32'h30; bus.s_wdata = 32'h13579BDF; bus.s_wstrb = 4'hF; bus.s_araddr = 32'h4;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.s_bvalid !== 1'b1 || bus.s_bresp !== 2'b00) begin bad++; $display("FAIL bp_b cyc=%0d bvalid=%b bresp=%b exp=1,00", i, bus.s_bvalid, bus.s_bresp); end
            total++; if (bus.s_rvalid !== 1'b1 || bus.s_rdata !== 32'h0F0F0F0F || bus.s_rresp !== 2'b00) begin bad++; $display("FAIL bp_r cyc=%0d rvalid=%b rdata=%h rresp=%b exp=1,0f0f0f0f,00", i, bus.s_rvalid, bus.s_rdata, bus.s_rresp); end
            tick();
        end
        bus.s_bready = 1'b1; bus.s_rready = 1'b1; tick(); bus.s_bready = 1'b0; bus.s_rready = 1'b0;
        total++; if (bus.s_bvalid !== 1'b0 || bus.s_rvalid !== 1'b0) begin bad++; $display("FAIL bp_drain bvalid=%b rvalid=%b exp=0,0", bus.s_bvalid, bus.s_rvalid); end
        do_read(32'h30, d, resp, rv, ok);
        total++; if (d !== 32'h13579BDF) begin bad++; $display("FAIL bp_rd got=%h exp=13579bdf", d); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic [31:0] d, d0; bit ok, rv;
        do_write(32'h0, 32'h0BADF00D, 4'hF, resp, ok);
        do_read(32'h0, d0, resp, rv, ok);
        do_write(32'h1000, 32'hCAFEF00D, 4'hF, resp, ok);
        total++; if (!ok || resp !== 2'b10) begin bad++; $display("FAIL oor_bresp got=%b exp=10", resp); end
        do_read(32'h1000, d, resp, rv, ok);
        total++; if (resp !== 2'b10 || d !== 32'h0) begin bad++; $display("FAIL oor_read rresp=%b rdata=%h exp=10,0", resp, d); end
        do_read(32'h0FFC, d, resp, rv, ok);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL last_word_rresp got=%b exp=00", resp); end
        do_read(32'h0, d, resp, rv, ok);
        total++; if (d !== d0) begin bad++; $display("FAIL oor_alias got=%h exp=%h", d, d0); end
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] resp; logic [31:0] d; bit ok, rv;
        bus.s_awaddr = 32'h4; bus.s_awvalid = 1'b1;
        tick(); bus.s_awvalid = 1'b0;
        total++; if (bus.s_awready !== 1'b0) begin bad++; $display("FAIL rmw_aw_held awready=%b exp=0", bus.s_awready); end
        areset = 1'b1; #1;
        total++; if (bus.s_awready !== 1'b1) begin bad++; $display("FAIL rmw_async awready=%b exp=1", bus.s_awready); end
        tick(); tick();
        areset = 1'b0;
        tick();
        total++; if (bus.s_bvalid !== 1'b0 || bus.s_awready !== 1'b1 || bus.s_wready !== 1'b1 || bus.s_arready !== 1'b1) begin bad++; $display("FAIL rmw_release bvalid=%b aw=%b w=%b ar=%b exp=0,1,1,1", bus.s_bvalid, bus.s_awready, bus.s_wready, bus.s_arready); end
        do_read(32'h4, d, resp, rv, ok);
        total++; if (d !== 32'h0F0F0F0F) begin bad++; $display("FAIL rmw_retained got=%h exp=0f0f0f0f", d); end
    endtask

    task automatic test_wprot();
        logic [1:0] resp; logic [31:0] d, d0; bit ok, rv;
`ifdef AXI_MEM_WPROT_EN
        do_read(32'h0, d0, resp, rv, ok);
        do_write(32'h0, 32'h12345678, 4'hF, resp, ok);
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL wprot_bresp got=%b exp=10", resp); end
        do_read(32'h0, d, resp, rv, ok);
        total++; if (d !== d0 || resp !== 2'b00) begin bad++; $display("FAIL wprot_keep got=%h rresp=%b exp=%h,00", d, resp, d0); end
        do_write(32'h3C, 32'h12345678, 4'hF, resp, ok);
        total++; if (resp !== 2'b10) begin bad++; $display("FAIL wprot_last_bresp got=%b exp=10", resp); end
        do_write(32'h40, 32'h87654321, 4'hF, resp, ok);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL wprot_first_free got=%b exp=00", resp); end
        do_read(32'h40, d, resp, rv, ok);
        total++; if (d !== 32'h87654321) begin bad++; $display("FAIL wprot_free_rd got=%h exp=87654321", d); end
`else
        d0 = 32'h12345678;
        do_write(32'h0, d0, 4'hF, resp, ok);
        total++; if (resp !== 2'b00) begin bad++; $display("FAIL noprot_bresp got=%b exp=00", resp); end
        do_read(32'h0, d, resp, rv, ok);
        total++; if (d !== 32'h12345678) begin bad++; $display("FAIL noprot_rd got=%h exp=12345678", d); end
`endif
    endtask

    initial begin
        idle_bus();
        areset = 1'b1;
        tick(); tick();
        test_reset();
        areset = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_strobe();
        test_decoupled();
        test_back_to_back();
        test_backpressure();
        test_out_of_range();
        test_reset_mid_write();
        test_wprot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_mem_param.md
Name: axi_lite_mem_param

Overview:
- Parametrised AXI4-Lite slave memory; successor to the fixed 32-bit instruction/data memory used in the AXI-Lite master/slave bench.
- Generalised in data width and depth.
- Adds byte strobes, out-of-range SLVERR responses, decoupled AW/W acceptance and independent read/write channels.
- Sits behind an AXI-Lite master or interconnect port as a general-purpose on-chip RAM.

Parameters:
- ADDR_W, 32, AXI address width in bits.
- DATA_W, 32, data width in bits; must be 32 or 64.
- DEPTH, 1024, number of DATA_W-bit words; must be a power of two.
- WPROT_WORDS, 16, number of low words that are read-only. Used only when AXI_MEM_WPROT_EN is defined.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid  in  1  AW valid.
- s_awready  out  1  AW ready.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  byte strobes.
- s_wvalid  in  1  W valid.
- s_wready  out  1  W ready.
- s_bresp  out  2  write response.
- s_bvalid  out  1  B valid.
- s_bready  in  1  B ready.
- s_araddr  in  ADDR_W  read address.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response.
- s_rvalid  out  1  R valid.
- s_rready  in  1  R ready.

Interface note (already decided): one clock, aclk; reset areset is asynchronous and active-high.

Behaviour:
- Word index = addr >> log2(DATA_W/8). Low byte-offset address bits are ignored; unaligned accesses are treated as aligned.
- An address is in range if its word index is less than DEPTH, i.e. byte address < DEPTH*DATA_W/8.
- Reset values: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0. Memory contents are not reset.
- Write FSM states:
  - W_IDLE: AW and W are captured independently, in either order. Each ready deasserts the cycle after its own handshake.
  - When both are held, go to W_RESP:
    - Memory is updated on that edge, only the bytes whose s_wstrb bit is 1.
    - bvalid=1.
    - bresp=OKAY (2'b00), or SLVERR (2'b10) with no memory update if the address is out of range.
  - W_RESP: hold bvalid/bresp stable until bready. On the handshake, return to W_IDLE with awready=wready=1 on the next cycle.
  - Max write throughput: one write per 2 cycles.
- Read FSM states:
  - R_IDLE: on the AR handshake in cycle N, arready=0 and rvalid=1 in cycle N+1, with rdata = mem[index].
  - Out-of-range reads return rdata=0 and rresp=SLVERR.
  - R_DATA: hold rdata/rresp/rvalid stable until rready. On the handshake, return to R_IDLE with arready=1 the next cycle.
- Read and write channels are fully independent.
  - Simultaneous read and write to the same word in the same edge: the read returns the pre-write data.
- Reset asserted mid-transaction: all outputs return to their reset values immediately (asynchronous). Partially captured AW/W are discarded; any write not yet committed is lost. Memory keeps its contents.
- A wstrb of 0 is a legal no-op write and returns OKAY.

Optional Feature:
- Macro AXI_MEM_WPROT_EN.
- Defined:
  - Words 0..WPROT_WORDS-1 are read-only.
  - Writes to them return SLVERR and leave memory unchanged.
  - Reads are unaffected.
- Undefined: the whole memory is writable and the WPROT_WORDS parameter is ignored.

Test Plan:
1. Basic write/read: DATA_W=32. Write 0xDEADBEEF to 0x4 with wstrb=0xF, then read 0x4 -> bresp=00, rdata=0xDEADBEEF, rresp=00, rvalid exactly one cycle after the AR handshake.
2. Byte strobes: preload 0x11223344 at 0x8, then write 0xAABBCCDD with wstrb=0x5 -> readback 0x11BB33DD.
3. Decoupled AW/W: AW at cycle 0, W at cycle 3 -> awready low cycles 1-3, B issued after the W handshake; readback is correct. Repeat with W arriving first.
4. Backpressure and out of range: hold bready=0 and rready=0 for 5 cycles -> bvalid/rvalid and their payloads stay stable. Write/read 0x1000 with DEPTH=1024 -> SLVERR, rdata=0, memory at 0x0 unchanged.
5. Reset mid-write: AW accepted, W pending, assert areset for 2 cycles -> bvalid=0 and all readies=1 after release, no memory update. A prior write to 0x4 is retained.
6. With AXI_MEM_WPROT_EN: write 0x12345678 to 0x0 -> SLVERR, readback shows the old value. Write to 0x40 -> OKAY.
